// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's shared data-memory port.
// Byte-maskable synchronous RAM plus an MMIO window holding a 64-bit prescaled timer and a tohost mailbox.
module dmem_responder #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DMEM_SZ_IN_KB = 1,
   parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
   parameter int unsigned TIMER_DIV     = 1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [31:0]           mem_addr_in,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_we_in,
   input  logic [3:0]            mem_mask_in,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  timer_irq,
   output logic                  tohost_valid,
   output logic [DATA_WIDTH-1:0] tohost_data
);

   localparam int unsigned DEPTH   = DMEM_SZ_IN_KB * 256;
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

   localparam logic [5:0] OFF_MTIME_LO = 6'h00;
   localparam logic [5:0] OFF_MTIME_HI = 6'h01;
   localparam logic [5:0] OFF_CMP_LO   = 6'h02;
   localparam logic [5:0] OFF_CMP_HI   = 6'h03;
   localparam logic [5:0] OFF_TOHOST   = 6'h04;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [31:0] bits);
      return (old_w & ~bits) | (new_w & bits);
   endfunction

   logic            is_mmio;
   logic [AW-1:0]   ram_idx;
   logic [5:0]      mmio_off;
   logic            wr_en;
   logic [31:0]     wr_bits;
   logic            ram_we;
   logic            unused_addr;

   assign is_mmio     = (mem_addr_in[31:8] == MMIO_BASE[31:8]);
   assign ram_idx     = mem_addr_in[AW+1:2];
   assign mmio_off    = mem_addr_in[7:2];
   assign wr_en       = mem_we_in && (mem_mask_in != 4'h0);
   assign wr_bits     = {{8{mem_mask_in[3]}}, {8{mem_mask_in[2]}},
                         {8{mem_mask_in[1]}}, {8{mem_mask_in[0]}}};
   assign ram_we      = wr_en && !is_mmio;
   assign unused_addr = ^mem_addr_in[1:0];

   // NOTE: the RAM array has no reset so it can map onto memory macros; software must not rely on its contents after power-up.
   logic [31:0] ram_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_mask_in[i]) ram_mem[ram_idx][8*i +: 8] <= mem_data_in[8*i +: 8];
         end
      end
   end

   logic [31:0]   mem_data_d,     mem_data_q;
   logic          timer_irq_d,    timer_irq_q;
   logic          tohost_valid_d, tohost_valid_q;
   logic [31:0]   tohost_data_d,  tohost_data_q;
   logic [63:0]   mtime_d,        mtime_q;
   logic [63:0]   mtimecmp_d,     mtimecmp_q;
   logic [PW-1:0] presc_d,        presc_q;
   logic          tick;
   logic [31:0]   mmio_rd;
   logic          wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_tohost;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latches).
      mmio_rd     = '0;
      wr_mtime_lo = 1'b0;
      wr_mtime_hi = 1'b0;
      wr_cmp_lo   = 1'b0;
      wr_cmp_hi   = 1'b0;
      wr_tohost   = 1'b0;
      case (mmio_off)
         OFF_MTIME_LO: begin mmio_rd = mtime_q[31:0];    wr_mtime_lo = 1'b1; end
         OFF_MTIME_HI: begin mmio_rd = mtime_q[63:32];   wr_mtime_hi = 1'b1; end
         OFF_CMP_LO:   begin mmio_rd = mtimecmp_q[31:0];  wr_cmp_lo  = 1'b1; end
         OFF_CMP_HI:   begin mmio_rd = mtimecmp_q[63:32]; wr_cmp_hi  = 1'b1; end
         OFF_TOHOST:   begin mmio_rd = tohost_data_q;     wr_tohost  = 1'b1; end
         default:      mmio_rd = '0;
      endcase
      if (!(wr_en && is_mmio)) begin
         wr_mtime_lo = 1'b0;
         wr_mtime_hi = 1'b0;
         wr_cmp_lo   = 1'b0;
         wr_cmp_hi   = 1'b0;
         wr_tohost   = 1'b0;
      end
   end

   always_comb begin
      // Read-first: the returned word is taken from state before this edge's write lands.
      mem_data_d = is_mmio ? mmio_rd : ram_mem[ram_idx];

      tick    = (presc_q == PRE_MAX);
      presc_d = tick ? '0 : presc_q + 1'b1;

      // A bus write to either half freezes the whole counter for that cycle.
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr_mtime_lo) begin
         mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], mem_data_in[31:0], wr_bits)};
      end else if (wr_mtime_hi) begin
         mtime_d = {merge_lanes(mtime_q[63:32], mem_data_in[31:0], wr_bits), mtime_q[31:0]};
      end

      mtimecmp_d = mtimecmp_q;
      if (wr_cmp_lo) mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0],  mem_data_in[31:0], wr_bits);
      if (wr_cmp_hi) mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], mem_data_in[31:0], wr_bits);

      timer_irq_d    = (mtime_q >= mtimecmp_q);
      tohost_valid_d = wr_tohost;
      tohost_data_d  = wr_tohost ? merge_lanes(tohost_data_q, mem_data_in[31:0], wr_bits)
                                 : tohost_data_q;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         mem_data_q     <= '0;
         timer_irq_q    <= 1'b0;
         tohost_valid_q <= 1'b0;
         tohost_data_q  <= '0;
         mtime_q        <= '0;
         mtimecmp_q     <= '1;
         presc_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         mem_data_q     <= mem_data_d;
         timer_irq_q    <= timer_irq_d;
         tohost_valid_q <= tohost_valid_d;
         tohost_data_q  <= tohost_data_d;
         mtime_q        <= mtime_d;
         mtimecmp_q     <= mtimecmp_d;
         presc_q        <= presc_d;
      end
   end

   assign mem_data_out = mem_data_q;
   assign timer_irq    = timer_irq_q;
   assign tohost_valid = tohost_valid_q;
   assign tohost_data  = tohost_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed stimulus, behavioural model feeds a scoreboard queue,
// and a negedge monitor pops and compares every cycle's outputs.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned TDIV  = 4;
   localparam logic [31:0] MMIO  = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [31:0] mem_addr_in = '0;
   logic [31:0] mem_data_in = '0;
   logic        mem_we_in = 1'b0;
   logic [3:0]  mem_mask_in = '0;
   logic [31:0] mem_data_out;
   logic        timer_irq;
   logic        tohost_valid;
   logic [31:0] tohost_data;

   dmem_responder #(
      .DATA_WIDTH(32), .DMEM_SZ_IN_KB(1), .MMIO_BASE(MMIO), .TIMER_DIV(TDIV)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
      .mem_we_in(mem_we_in), .mem_mask_in(mem_mask_in),
      .mem_data_out(mem_data_out), .timer_irq(timer_irq),
      .tohost_valid(tohost_valid), .tohost_data(tohost_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      bit          data_known;
      logic        irq;
      logic        tv;
      logic [31:0] td;
   } exp_t;

   exp_t exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, req);
      end
   endtask

   // Reference model: RAM as a sparse word map (absent = unknown contents), timer as a 64-bit count.
   logic [31:0] m_ram [int unsigned];
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   int unsigned m_cycles;
   logic [31:0] m_tohost;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_mtime  = '0;
      m_cmp    = '1;
      m_cycles = 0;
      m_tohost = '0;
   endtask

   task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m);
      exp_t        e;
      bit          mmio;
      bit          wr;
      int unsigned idx;
      logic [7:0]  off;
      mmio = (a[31:8] == MMIO[31:8]);
      idx  = (a >> 2) % DEPTH;
      off  = a[7:0] & 8'hFC;
      wr   = w && (m != 4'h0);

      e.data_known = 1'b1;
      e.data       = '0;
      if (mmio) begin
         case (off)
            8'h00: e.data = m_mtime[31:0];
            8'h04: e.data = m_mtime[63:32];
            8'h08: e.data = m_cmp[31:0];
            8'h0C: e.data = m_cmp[63:32];
            8'h10: e.data = m_tohost;
            default: e.data = '0;
         endcase
      end else if (m_ram.exists(idx)) begin
         e.data = m_ram[idx];
      end else begin
         e.data_known = 1'b0;
      end
      e.irq = (m_mtime >= m_cmp);
      e.tv  = mmio && wr && (off == 8'h10);

      m_cycles++;
      if (mmio && wr && off == 8'h00)      m_mtime[31:0]  = merge(m_mtime[31:0], d, m);
      else if (mmio && wr && off == 8'h04) m_mtime[63:32] = merge(m_mtime[63:32], d, m);
      else if (m_cycles % TDIV == 0)       m_mtime        = m_mtime + 64'd1;
      if (mmio && wr && off == 8'h08) m_cmp[31:0]  = merge(m_cmp[31:0], d, m);
      if (mmio && wr && off == 8'h0C) m_cmp[63:32] = merge(m_cmp[63:32], d, m);
      if (e.tv) m_tohost = merge(m_tohost, d, m);
      if (!mmio && wr) begin
         if (m == 4'hF)              m_ram[idx] = d;
         else if (m_ram.exists(idx)) m_ram[idx] = merge(m_ram[idx], d, m);
      end
      e.td = m_tohost;
      exp_q.push_back(e);
   endtask

   // One bus access per cycle: drive just after an edge, let the DUT sample, then record the expectation.
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m);
      #1;
      mem_addr_in = a;
      mem_data_in = d;
      mem_we_in   = w;
      mem_mask_in = m;
      @(posedge clk);
      model_edge(a, d, w, m);
   endtask

   task automatic rd(input logic [31:0] a);
      access(a, 32'h0, 1'b0, 4'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      access(a, d, 1'b1, 4'hF);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},   mem_data_out, 32'h0);
      check({tag, "_irq"},    {31'h0, timer_irq}, 32'h0);
      check({tag, "_tv"},     {31'h0, tohost_valid}, 32'h0);
      check({tag, "_tdata"},  tohost_data, 32'h0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #1;
      mem_we_in = 1'b0;
      arst_n    = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (arst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.data_known) check("rd_data", mem_data_out, e.data);
         check("timer_irq",    {31'h0, timer_irq},    {31'h0, e.irq});
         check("tohost_valid", {31'h0, tohost_valid}, {31'h0, e.tv});
         check("tohost_data",  tohost_data,           e.td);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int unsigned kind;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      arst_n = 1'b1;

      // Timer with a divide-by-4 prescaler: lo reads 0,0,0,0,1,1,...
      repeat (6) rd(MMIO + 32'h00);
      wr(MMIO + 32'h00, 32'hFFFF_FFFF);
      repeat (8) rd(MMIO + 32'h04);

      // Fill RAM with known contents.
      for (int i = 0; i < DEPTH; i++) wr(32'(i) << 2, $urandom);

      // Full-word write then read-back.
      wr(32'h40, 32'hDEAD_BEEF);
      rd(32'h40);
      // Single-lane write, then a mask-0 write that must change nothing.
      access(32'h40, 32'h00AA_0000, 1'b1, 4'h4);
      rd(32'h40);
      access(32'h40, 32'h1234_5678, 1'b1, 4'h0);
      rd(32'h40);
      // Aliasing past the end of RAM and read-first on a same-edge write.
      wr(32'h400, 32'h11);
      rd(32'h000);
      wr(32'h8, 32'hCAFE_F00D);
      rd(32'h8);

      // Compare/interrupt: raise at mtime >= 20, then drop by moving the compare away.
      wr(MMIO + 32'h04, 32'h0);
      wr(MMIO + 32'h00, 32'h0);
      wr(MMIO + 32'h0C, 32'h0);
      wr(MMIO + 32'h08, 32'd20);
      repeat (100) rd(MMIO + 32'h00);
      wr(MMIO + 32'h08, 32'hFFFF_FFFF);
      repeat (4) rd(MMIO + 32'h08);

      // tohost mailbox pulses, including a partial-lane update.
      wr(MMIO + 32'h10, 32'h1);
      repeat (3) rd(MMIO + 32'h10);
      access(MMIO + 32'h10, 32'h5A5A_5A5A, 1'b1, 4'h3);
      access(MMIO + 32'h10, 32'hA5A5_A5A5, 1'b1, 4'h8);
      repeat (2) rd(MMIO + 32'h14);

      // 64-bit wrap: irq holds while mtime >= cmp and clears once mtime wraps past zero.
      wr(MMIO + 32'h04, 32'hFFFF_FFFF);
      wr(MMIO + 32'h00, 32'hFFFF_FFF0);
      wr(MMIO + 32'h08, 32'hFFFF_FFF8);
      repeat (90) rd(MMIO + 32'h04);

      // Asynchronous reset mid-run; RAM contents survive.
      mid_reset();
      rd(32'h40);
      repeat (6) rd(MMIO + 32'h00);

      // Randomized mix of RAM and MMIO traffic.
      for (int n = 0; n < 3000; n++) begin
         kind = $urandom_range(0, 9);
         d    = $urandom;
         if (kind < 6) begin
            a = $urandom;
            if (a[31:8] == MMIO[31:8]) a[31] = 1'b0;
         end else begin
            a = MMIO | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
            if (a[7:2] == 6'h03 || a[7:2] == 6'h01) d = 32'($urandom_range(0, 2));
         end
         access(a, d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      #1;
      mem_we_in = 1'b0;
      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
